// File: rtl/loader_pkg.sv
// Shared constants and state encoding for the boot-time program loader.
package loader_pkg;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_ADDR_STEP  = 4;
    localparam int DEF_MAX_WORDS  = 256;
    localparam int DEF_RUN_CYCLES = 830;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_HDR_HI = 4'd1;
    localparam logic [3:0] ST_HDR_LO = 4'd2;
    localparam logic [3:0] ST_BYTES  = 4'd3;
    localparam logic [3:0] ST_SETUP  = 4'd4;
    localparam logic [3:0] ST_STROBE = 4'd5;
    localparam logic [3:0] ST_HOLD   = 4'd6;
    localparam logic [3:0] ST_RUN    = 4'd7;
    localparam logic [3:0] ST_DONE   = 4'd8;
    localparam logic [3:0] ST_ERR    = 4'd9;

    typedef enum logic [3:0] {
        S_IDLE   = ST_IDLE,
        S_HDR_HI = ST_HDR_HI,
        S_HDR_LO = ST_HDR_LO,
        S_BYTES  = ST_BYTES,
        S_SETUP  = ST_SETUP,
        S_STROBE = ST_STROBE,
        S_HOLD   = ST_HOLD,
        S_RUN    = ST_RUN,
        S_DONE   = ST_DONE,
        S_ERR    = ST_ERR
    } state_t;

endpackage

// File: rtl/loader_word_assembler.sv
// Collects stream bytes MSB first into a 32-bit instruction word.
module loader_word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        shift,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        word_full
);

    logic [23:0] sh_q;
    logic [1:0]  cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (shift) begin
            sh_q  <= {sh_q[15:0], byte_in};
            cnt_q <= cnt_q + 2'd1;
        end
    end

    // word_out already includes the byte on byte_in, so when word_full
    // is set the byte being shifted this cycle completes the word.
    assign word_out  = {sh_q, byte_in};
    assign word_full = (cnt_q == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/program_loader.sv
// Boot loader: streams a length-prefixed program into instruction
// memory, then runs the CPU for a fixed number of cycles.
module program_loader
    import loader_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDR_STEP  = DEF_ADDR_STEP,
    parameter int MAX_WORDS  = DEF_MAX_WORDS,
    parameter int RUN_CYCLES = DEF_RUN_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic [WIDTH-1:0] addrIn,
    output logic [WIDTH-1:0] dataOut,
    output logic             wrIn,
    output logic             go_contr,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CNT_W = HDR_BYTES * 8;

    state_t           state_q, state_d;
    logic [7:0]       hdr_hi_q;
    logic [CNT_W-1:0] n_words_q;
    logic [CNT_W-1:0] word_cnt_q;
    logic [CNT_W-1:0] word_cnt_nxt;
    logic [CNT_W-1:0] n_hdr;
    logic [WIDTH-1:0] addr_cnt_q;
    logic [31:0]      run_cnt_q;
    logic             xfer;
    logic             start_go;
    logic             asm_clr;
    logic             asm_shift;
    logic [31:0]      asm_word;
    logic             asm_full;

    assign xfer         = byte_valid & byte_ready;
    assign n_hdr        = {hdr_hi_q, byte_data};
    assign word_cnt_nxt = word_cnt_q + 1'b1;
    assign asm_shift    = xfer & (state_q == S_BYTES);
    assign asm_clr      = start_go | abort;

    loader_word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clr       (asm_clr),
        .shift     (asm_shift),
        .byte_in   (byte_data),
        .word_out  (asm_word),
        .word_full (asm_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        byte_ready = 1'b0;
        wrIn       = 1'b0;
        go_contr   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        err        = 1'b0;
        start_go   = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                busy     = 1'b0;
                done     = (state_q == S_DONE);
                err      = (state_q == S_ERR);
                start_go = start & ~abort;
                if (start) state_d = S_HDR_HI;
            end
            S_HDR_HI: begin
                byte_ready = ~abort;
                if (byte_valid) state_d = S_HDR_LO;
            end
            S_HDR_LO: begin
                byte_ready = ~abort;
                if (byte_valid) begin
                    if (n_hdr == '0)
                        state_d = S_RUN;
                    else if (32'(n_hdr) > MAX_WORDS)
                        state_d = S_ERR;
                    else
                        state_d = S_BYTES;
                end
            end
            S_BYTES: begin
                byte_ready = ~abort;
                if (byte_valid && asm_full) state_d = S_SETUP;
            end
            S_SETUP:  state_d = S_STROBE;
            S_STROBE: begin
                wrIn    = 1'b1;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (word_cnt_nxt < n_words_q) state_d = S_BYTES;
                else                          state_d = S_RUN;
            end
            S_RUN: begin
                go_contr = 1'b1;
                if (RUN_CYCLES != 0 &&
                    run_cnt_q == 32'(RUN_CYCLES - 1))
                    state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    // Address/data registers latch on the completing byte so they are
    // already valid during SETUP and survive abort untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hdr_hi_q   <= '0;
            n_words_q  <= '0;
            word_cnt_q <= '0;
            addr_cnt_q <= '0;
            addrIn     <= '0;
            dataOut    <= '0;
            run_cnt_q  <= '0;
        end else begin
            if (state_q == S_RUN && RUN_CYCLES != 0 && !abort)
                run_cnt_q <= run_cnt_q + 32'd1;
            else
                run_cnt_q <= '0;
            if (start_go) begin
                word_cnt_q <= '0;
                addr_cnt_q <= '0;
            end
            if (!abort) begin
                if (xfer && state_q == S_HDR_HI)
                    hdr_hi_q <= byte_data;
                if (xfer && state_q == S_HDR_LO)
                    n_words_q <= n_hdr;
                if (asm_shift && asm_full) begin
                    dataOut <= WIDTH'(asm_word);
                    addrIn  <= addr_cnt_q;
                end
                if (state_q == S_HOLD) begin
                    word_cnt_q <= word_cnt_nxt;
                    addr_cnt_q <= addr_cnt_q + WIDTH'(ADDR_STEP);
                end
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: directed program loads.
module tb_program_loader;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready;
    logic [31:0] addrIn, dataOut;
    logic        wrIn, go_contr, busy, done, err;

    logic        h_start = 1'b0;
    logic        h_abort = 1'b0;
    logic        h_valid = 1'b0;
    logic [7:0]  h_data = '0;
    logic        h_ready;
    logic [31:0] h_addr, h_dout;
    logic        h_wr, h_go, h_busy, h_done, h_err;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_seen = 0;
    logic prev_wr = 1'b0;
    wr_t exp_q[$];
    logic [31:0] prog [8];

    always #5 clk = ~clk;

    program_loader dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .addrIn(addrIn), .dataOut(dataOut),
        .wrIn(wrIn), .go_contr(go_contr), .busy(busy),
        .done(done), .err(err)
    );

    program_loader #(.RUN_CYCLES(0)) dut_h (
        .clk(clk), .reset(reset), .start(h_start), .abort(h_abort),
        .byte_valid(h_valid), .byte_data(h_data),
        .byte_ready(h_ready), .addrIn(h_addr), .dataOut(h_dout),
        .wrIn(h_wr), .go_contr(h_go), .busy(h_busy),
        .done(h_done), .err(h_err)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every strobe pops one expected write.
    always @(negedge clk) begin
        wr_t e;
        if (!reset) begin
            if (wrIn && go_contr) chk("wr_go_overlap", 1, 0);
            if (wrIn) begin
                chk("wr_one_cycle", 32'(prev_wr), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", addrIn, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", addrIn, e.addr);
                    chk("wr_data", dataOut, e.data);
                end
                wr_seen++;
            end
            prev_wr = wrIn;
        end else begin
            prev_wr = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic s, input logic a);
        start = s;
        abort = a;
        tick();
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int waitc;
        if (gaps) repeat ($urandom_range(0, 2)) begin
            byte_valid = 1'b0;
            tick();
        end
        byte_valid = 1'b1;
        byte_data  = b;
        waitc = 0;
        forever begin
            @(negedge clk);
            if (byte_ready) begin
                tick();
                break;
            end
            waitc++;
            if (waitc > 50) begin
                chk("byte_ready_timeout", 0, 1);
                break;
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [15:0] n, input bit gaps);
        send_byte(n[15:8], gaps);
        send_byte(n[7:0], gaps);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        send_byte(w[31:24], gaps);
        send_byte(w[23:16], gaps);
        send_byte(w[15:8], gaps);
        send_byte(w[7:0], gaps);
    endtask

    task automatic expect_words(input int n);
        for (int k = 0; k < n; k++)
            exp_q.push_back('{addr: 32'(k * 4), data: prog[k]});
    endtask

    task automatic wait_go();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (go_contr) return;
        end
        chk("go_timeout", 0, 1);
    endtask

    task automatic count_run(output int cnt);
        cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (go_contr) cnt++;
            else if (cnt > 0) break;
        end
    endtask

    initial begin
        int cnt;
        prog[0] = 32'h1122_3344; prog[1] = 32'h5566_7788;
        prog[2] = 32'h99AA_BBCC; prog[3] = 32'hDDEE_FF00;
        prog[4] = 32'h0102_0304; prog[5] = 32'hA5A5_5A5A;
        prog[6] = 32'hDEAD_BEEF; prog[7] = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs",
            {26'd0, byte_ready, wrIn, go_contr, busy, done, err}, 0);
        chk("rst_addr", addrIn, 0);
        chk("rst_data", dataOut, 0);
        reset = 1'b0;
        tick();

        // 1: single-word program, then timed run
        prog[0] = 32'hC01F_0001;
        wr_seen = 0;
        pulse(1, 0);
        chk("t1_busy", busy, 1);
        expect_words(1);
        send_hdr(16'd1, 0);
        send_word(prog[0], 0);
        count_run(cnt);
        chk("t1_run_len", cnt, 830);
        chk("t1_done", done, 1);
        chk("t1_busy_done", busy, 0);
        chk("t1_writes", wr_seen, 1);

        // 2: seven words with gaps, start while busy ignored
        prog[0] = 32'h1122_3344;
        wr_seen = 0;
        pulse(1, 0);
        chk("t2_done_clr", done, 0);
        expect_words(7);
        send_hdr(16'd7, 1);
        send_word(prog[0], 1);
        send_byte(prog[1][31:24], 1);
        pulse(1, 0);
        for (int k = 0; k < 3; k++) begin
            logic [31:0] w;
            w = prog[1];
            send_byte(w[23 - 8*k -: 8], 1);
        end
        for (int k = 2; k < 7; k++) send_word(prog[k], 1);
        wait_go();
        chk("t2_writes", wr_seen, 7);
        chk("t2_queue_empty", exp_q.size(), 0);

        // 5: abort in RUN with simultaneous start
        repeat (5) tick();
        pulse(1, 1);
        chk("t5_go_off", go_contr, 0);
        chk("t5_idle", {busy, done, err}, 0);
        repeat (3) tick();
        chk("t5_start_dropped", busy, 0);
        chk("t5_addr_kept", addrIn, 32'h18);
        chk("t5_data_kept", dataOut, 32'hDEAD_BEEF);

        // 3: oversize header goes to ERR, start recovers
        wr_seen = 0;
        pulse(1, 0);
        send_hdr(16'h0101, 0);
        chk("t3_err", err, 1);
        chk("t3_flags", {byte_ready, busy, go_contr}, 0);
        repeat (5) tick();
        chk("t3_no_go", go_contr, 0);
        chk("t3_no_write", wr_seen, 0);
        pulse(1, 0);
        chk("t3_err_clr", err, 0);
        chk("t3_busy", busy, 1);
        prog[0] = 32'h0BAD_F00D;
        prog[1] = 32'h1357_9BDF;
        expect_words(2);
        send_hdr(16'd2, 0);
        send_word(prog[0], 0);
        send_word(prog[1], 0);
        wait_go();
        chk("t3_writes", wr_seen, 2);
        pulse(0, 1);

        // 4: reset during strobe of the third word
        wr_seen = 0;
        pulse(1, 0);
        expect_words(5);
        send_hdr(16'd5, 0);
        for (int k = 0; k < 3; k++) send_word(prog[k], 0);
        tick();
        chk("t4_in_strobe", wrIn, 1);
        reset = 1'b1;
        #1;
        chk("t4_wr_async", wrIn, 0);
        chk("t4_outputs",
            {26'd0, byte_ready, wrIn, go_contr, busy, done, err}, 0);
        chk("t4_addr", addrIn, 0);
        chk("t4_data", dataOut, 0);
        exp_q.delete();
        chk("t4_writes_before", wr_seen, 2);
        @(posedge clk);
        #3;
        reset = 1'b0;
        tick();
        wr_seen = 0;
        prog[0] = 32'hFEED_0001;
        prog[1] = 32'hFEED_0002;
        pulse(1, 0);
        expect_words(2);
        send_hdr(16'd2, 0);
        send_word(prog[0], 0);
        send_word(prog[1], 0);
        wait_go();
        chk("t4_reload", wr_seen, 2);
        pulse(0, 1);

        // 6: empty program runs immediately
        wr_seen = 0;
        pulse(1, 0);
        send_hdr(16'd0, 0);
        chk("t6_go_now", go_contr, 1);
        repeat (4) tick();
        chk("t6_no_write", wr_seen, 0);
        pulse(0, 1);
        chk("t6_abort", go_contr, 0);

        // 6b: RUN_CYCLES = 0 holds until abort
        h_start = 1'b1;
        tick();
        h_start = 1'b0;
        h_valid = 1'b1;
        h_data  = 8'h00;
        cnt = 0;
        for (int i = 0; i < 20 && !h_go; i++) tick();
        h_valid = 1'b0;
        chk("t6b_go", h_go, 1);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (h_go) cnt++;
        end
        chk("t6b_hold", cnt, 1000);
        chk("t6b_no_write", h_addr, 0);
        tick();
        h_abort = 1'b1;
        tick();
        h_abort = 1'b0;
        chk("t6b_abort", {h_go, h_busy, h_done, h_err, h_wr}, 0);

        repeat (2) tick();
        chk("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
